// File: rtl/pong_pkg.sv
// ============================================================================
// Module  : pong_pkg
// Purpose : Shared Pong playfield/ball constants, ball FSM state type.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package pong_pkg;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int BALL_SIZE   = 2;
  localparam int PADDLE_H    = 16;
  localparam int PADDLE_LX   = 4;
  localparam int PADDLE_RX   = 155;
  localparam int SERVE_TICKS = 15;
  localparam int MAX_STEP    = 4;
  localparam int STEP_W      = 3;

  // Centre position, also consumed by the draw logic
  localparam int CX = (SCREEN_W - BALL_SIZE) / 2;
  localparam int CY = (SCREEN_H - BALL_SIZE) / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RUN   = 2'd2,
    MISS  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ball_motion_if.sv
// ============================================================================
// Module  : ball_motion_if
// Purpose : Control/paddle inputs and ball state outputs of the ball engine.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ball_motion_if;

  logic       gameStart;
  logic       frameCounter;
  logic [6:0] paddleLY;
  logic [6:0] paddleRY;
  logic [7:0] ballX;
  logic [6:0] ballY;
  logic       dirX;
  logic       scoreL;
  logic       scoreR;
  logic       active;

  modport master (
    output gameStart, frameCounter, paddleLY, paddleRY,
    input  ballX, ballY, dirX, scoreL, scoreR, active
  );

  modport slave (
    input  gameStart, frameCounter, paddleLY, paddleRY,
    output ballX, ballY, dirX, scoreL, scoreR, active
  );

endinterface

`default_nettype wire

// File: rtl/pong_ball_collide.sv
// ============================================================================
// Module  : pong_ball_collide
// Purpose : Combinational next position, wall bounce and paddle hit/miss.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_ball_collide
  import pong_pkg::*;
(
  input  logic [7:0]        i_x,
  input  logic [6:0]        i_y,
  input  logic              i_dir_x,
  input  logic              i_dir_y,
  input  logic [STEP_W-1:0] i_step,
  input  logic [6:0]        i_paddle_ly,
  input  logic [6:0]        i_paddle_ry,
  output logic [7:0]        o_x,
  output logic [6:0]        o_y,
  output logic              o_dir_x,
  output logic              o_dir_y,
  output logic              o_miss_l,
  output logic              o_miss_r
);

  localparam logic signed [8:0] c_y_max      = 9'(SCREEN_H - BALL_SIZE);
  localparam logic signed [8:0] c_left_face  = 9'(PADDLE_LX);
  localparam logic signed [8:0] c_right_face = 9'(PADDLE_RX);
  localparam logic signed [8:0] c_ball_s     = 9'(BALL_SIZE);
  localparam logic [8:0]        c_ball_u     = 9'(BALL_SIZE);
  localparam logic [8:0]        c_pad_h      = 9'(PADDLE_H);

  logic signed [8:0] w_step;
  logic signed [8:0] w_nx;
  logic signed [8:0] w_ny;
  logic              w_ovl_l;
  logic              w_ovl_r;
  logic              w_at_left;
  logic              w_at_right;

  assign w_step = $signed({{(9-STEP_W){1'b0}}, i_step});
  assign w_nx   = i_dir_x ? ($signed({1'b0, i_x}) + w_step) : ($signed({1'b0, i_x}) - w_step);
  assign w_ny   = i_dir_y ? ($signed({2'b00, i_y}) + w_step) : ($signed({2'b00, i_y}) - w_step);

  // Overlap is judged on the pre-move y so a fast ball cannot tunnel past
  assign w_ovl_l = (({2'b00, i_y} + c_ball_u) > {2'b00, i_paddle_ly}) &&
                   ({2'b00, i_y} < ({2'b00, i_paddle_ly} + c_pad_h));
  assign w_ovl_r = (({2'b00, i_y} + c_ball_u) > {2'b00, i_paddle_ry}) &&
                   ({2'b00, i_y} < ({2'b00, i_paddle_ry} + c_pad_h));

  assign w_at_left  = !i_dir_x && (w_nx <= c_left_face);
  assign w_at_right = i_dir_x && ((w_nx + c_ball_s - 9'sd1) >= c_right_face);

  always_comb begin
    o_x      = w_nx[7:0];
    o_y      = w_ny[6:0];
    o_dir_x  = i_dir_x;
    o_dir_y  = i_dir_y;
    o_miss_l = 1'b0;
    o_miss_r = 1'b0;

    if (w_ny < 9'sd0) begin
      o_y     = 7'd0;
      o_dir_y = 1'b1;
    end else if (w_ny > c_y_max) begin
      o_y     = c_y_max[6:0];
      o_dir_y = 1'b0;
    end

    if (w_at_left) begin
      if (w_ovl_l) begin
        o_x     = 8'(PADDLE_LX + 1);
        o_dir_x = 1'b1;
      end else begin
        o_miss_l = 1'b1;
      end
    end else if (w_at_right) begin
      if (w_ovl_r) begin
        o_x     = 8'(PADDLE_RX - BALL_SIZE);
        o_dir_x = 1'b0;
      end else begin
        o_miss_r = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ball_motion.sv
// ============================================================================
// Module  : ball_motion
// Purpose : Frame-tick Pong ball engine: serve, move, bounce, score.
//           Optional BALL_SPEEDUP_EN: step grows per paddle hit up to MAX_STEP.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_motion
  import pong_pkg::*;
(
  input  logic          clock,
  input  logic          resetn,
  ball_motion_if.slave  bus
);

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [7:0]        r_x, w_x_nxt;
  logic [6:0]        r_y, w_y_nxt;
  logic              r_dir_x, w_dir_x_nxt;
  logic              r_dir_y, w_dir_y_nxt;
  logic              r_score_l, w_score_l_nxt;
  logic              r_score_r, w_score_r_nxt;
  logic              r_active, w_active_nxt;
  logic [STEP_W-1:0] w_step;

  logic [7:0]        w_col_x;
  logic [6:0]        w_col_y;
  logic              w_col_dir_x;
  logic              w_col_dir_y;
  logic              w_miss_l;
  logic              w_miss_r;

`ifdef BALL_SPEEDUP_EN
  logic [STEP_W-1:0] r_step, w_step_nxt;
  assign w_step = r_step;
`else
  assign w_step = STEP_W'(1);
`endif

  pong_ball_collide u_collide (
    .i_x         (r_x),
    .i_y         (r_y),
    .i_dir_x     (r_dir_x),
    .i_dir_y     (r_dir_y),
    .i_step      (w_step),
    .i_paddle_ly (bus.paddleLY),
    .i_paddle_ry (bus.paddleRY),
    .o_x         (w_col_x),
    .o_y         (w_col_y),
    .o_dir_x     (w_col_dir_x),
    .o_dir_y     (w_col_dir_y),
    .o_miss_l    (w_miss_l),
    .o_miss_r    (w_miss_r)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_dir_x_nxt   = r_dir_x;
    w_dir_y_nxt   = r_dir_y;
    w_score_l_nxt = 1'b0;
    w_score_r_nxt = 1'b0;
    w_active_nxt  = r_active;
`ifdef BALL_SPEEDUP_EN
    w_step_nxt    = r_step;
`endif

    if (!bus.gameStart) begin
      w_state_nxt  = IDLE;
      w_x_nxt      = 8'(CX);
      w_y_nxt      = 7'(CY);
      w_active_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.frameCounter) begin
            w_cnt_nxt   = 4'(SERVE_TICKS);
            w_state_nxt = SERVE;
          end
        end
        SERVE: begin
          if (bus.frameCounter) begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              w_state_nxt  = RUN;
              w_active_nxt = 1'b1;
`ifdef BALL_SPEEDUP_EN
              w_step_nxt   = STEP_W'(1);
`endif
            end
          end
        end
        RUN: begin
          if (bus.frameCounter) begin
            if (w_miss_l || w_miss_r) begin
              // Miss freezes the ball; MISS recentres it next cycle
              w_state_nxt   = MISS;
              w_active_nxt  = 1'b0;
              w_score_r_nxt = w_miss_l;
              w_score_l_nxt = w_miss_r;
            end else begin
              w_x_nxt     = w_col_x;
              w_y_nxt     = w_col_y;
              w_dir_x_nxt = w_col_dir_x;
              w_dir_y_nxt = w_col_dir_y;
`ifdef BALL_SPEEDUP_EN
              // Only a paddle hit can reverse dirX while running
              if ((w_col_dir_x != r_dir_x) && (r_step < STEP_W'(MAX_STEP)))
                w_step_nxt = r_step + STEP_W'(1);
`endif
            end
          end
        end
        MISS: begin
          w_x_nxt     = 8'(CX);
          w_y_nxt     = 7'(CY);
          w_dir_x_nxt = ~r_score_r;
          w_cnt_nxt   = 4'(SERVE_TICKS);
          w_state_nxt = SERVE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= 4'd0;
      r_x       <= 8'(CX);
      r_y       <= 7'(CY);
      r_dir_x   <= 1'b1;
      r_dir_y   <= 1'b1;
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
      r_active  <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      r_step    <= STEP_W'(1);
`endif
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_dir_x   <= w_dir_x_nxt;
      r_dir_y   <= w_dir_y_nxt;
      r_score_l <= w_score_l_nxt;
      r_score_r <= w_score_r_nxt;
      r_active  <= w_active_nxt;
`ifdef BALL_SPEEDUP_EN
      r_step    <= w_step_nxt;
`endif
    end
  end

  assign bus.ballX  = r_x;
  assign bus.ballY  = r_y;
  assign bus.dirX   = r_dir_x;
  assign bus.scoreL = r_score_l;
  assign bus.scoreR = r_score_r;
  assign bus.active = r_active;

endmodule

`default_nettype wire

// File: tb/tb_ball_motion.sv
// ============================================================================
// Module  : tb_ball_motion
// Purpose : Randomized play of ball_motion against a behavioural Pong model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ball_motion;

`ifdef BALL_SPEEDUP_EN
  localparam int SPEEDUP = 1;
`else
  localparam int SPEEDUP = 0;
`endif

  localparam int M_IDLE = 0, M_SERVE = 1, M_RUN = 2, M_MISS = 3;

  logic clock = 1'b0;
  logic resetn;

  ball_motion_if bus ();

  ball_motion dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #10 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  int m_mode, m_cnt, m_x, m_y, m_dx, m_dy, m_step, m_act;
  bit m_sl, m_sr;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_x = 79; m_y = 59;
    m_dx = 1; m_dy = 1; m_step = 1; m_act = 0; m_sl = 0; m_sr = 0;
  endtask

  // Expected state after one clock edge with the given inputs
  task automatic model_step(input bit gs, input bit tick, input int ply, input int pry);
    bit prev_sr;
    int nx, ny, ndx, ndy;
    bit miss, hit;
    prev_sr = m_sr;
    m_sl = 0;
    m_sr = 0;
    if (!gs) begin
      m_mode = M_IDLE; m_x = 79; m_y = 59; m_act = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (tick) begin m_cnt = 15; m_mode = M_SERVE; end
      M_SERVE: if (tick) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin m_mode = M_RUN; m_act = 1; m_step = 1; end
      end
      M_RUN: if (tick) begin
        nx = m_dx ? m_x + m_step : m_x - m_step;
        ny = m_dy ? m_y + m_step : m_y - m_step;
        ndx = m_dx; ndy = m_dy; miss = 0; hit = 0;
        if (ny < 0) begin ny = 0; ndy = 1; end
        else if (ny > 118) begin ny = 118; ndy = 0; end
        if (m_dx == 0 && nx <= 4) begin
          if (m_y + 2 > ply && m_y < ply + 16) begin nx = 5; ndx = 1; hit = 1; end
          else begin miss = 1; m_sr = 1; end
        end else if (m_dx == 1 && nx + 1 >= 155) begin
          if (m_y + 2 > pry && m_y < pry + 16) begin nx = 153; ndx = 0; hit = 1; end
          else begin miss = 1; m_sl = 1; end
        end
        if (miss) begin
          m_mode = M_MISS; m_act = 0;
        end else begin
          m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
          if (hit && SPEEDUP == 1) m_step = (m_step < 4) ? m_step + 1 : 4;
        end
      end
      default: begin
        m_x = 79; m_y = 59; m_dx = prev_sr ? 0 : 1;
        m_cnt = 15; m_mode = M_SERVE;
      end
    endcase
  endtask

  task automatic compare_all(input string pfx);
    check({pfx, "ballX"},  16'(bus.ballX),  16'(m_x));
    check({pfx, "ballY"},  16'(bus.ballY),  16'(m_y));
    check({pfx, "dirX"},   16'(bus.dirX),   16'(m_dx));
    check({pfx, "scoreL"}, 16'(bus.scoreL), 16'(m_sl));
    check({pfx, "scoreR"}, 16'(bus.scoreR), 16'(m_sr));
    check({pfx, "active"}, 16'(bus.active), 16'(m_act));
    check({pfx, "score_excl"}, 16'(bus.scoreL & bus.scoreR), 16'd0);
  endtask

  function automatic int track(input int y);
    int t;
    t = y - int'($urandom_range(0, 17));
    if (t < 0) t = 0;
    return t;
  endfunction

  initial begin
    bit gs, tick;
    int ply, pry;
    int next_rst;
    resetn = 1'b0;
    bus.gameStart = 1'b0;
    bus.frameCounter = 1'b0;
    bus.paddleLY = 7'd0;
    bus.paddleRY = 7'd0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    compare_all("rst_");

    next_rst = 4000;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clock);
      resetn = 1'b1;
      gs   = ($urandom_range(0, 999) != 0);
      tick = ($urandom_range(0, 2) != 0);
      ply  = ($urandom_range(0, 3) != 0) ? track(m_y) : int'($urandom_range(0, 127));
      pry  = ($urandom_range(0, 3) != 0) ? track(m_y) : int'($urandom_range(0, 127));
      model_step(gs, tick, ply, pry);
      bus.gameStart    = gs;
      bus.frameCounter = tick;
      bus.paddleLY     = 7'(ply);
      bus.paddleRY     = 7'(pry);
      @(posedge clock);
      #1;
      compare_all("");
      if (i > next_rst && m_mode == M_RUN) begin
        // Asynchronous reset mid-rally, well away from any clock edge
        next_rst = i + 5000;
        #5;
        resetn = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst_");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
